keccak_round_ctrl: RTL and testbench
====================================

KECCAK_ROUND_CTRL -- requirements
Module: keccak_round_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 24, the rounds per permutation.
REQ-002 The block SHALL have parameter UNROLL, default 1, the rounds per cycle; legal values are 1, 2, 3 and 4.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: the single clock has one reset, which is synchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: a new 1600-bit state is presented to the datapath input mux.
REQ-006 Port in_ready, output, 1 bit: the controller accepts input this cycle.
REQ-007 Port out_valid, output, 1 bit: the datapath state register holds a completed permutation.
REQ-008 Port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-009 Port abort, input, 1 bit: synchronous cancel of any permutation in progress.
REQ-010 Port load_en, output, 1 bit: the state register captures the input-mux value.
REQ-011 Port round_en, output, 1 bit: the state register captures the round-logic output.
REQ-012 Port round, output, 7 bits: index of the first round applied this cycle; it drives the RC lookup, and lane k of the unroll uses round+k.
REQ-013 Port busy, output, 1 bit: high in the RUN state.
REQ-014 Port perm_count, output, 16 bits: the number of completed output handshakes.

Function
REQ-015 The block SHALL implement the states IDLE, RUN and DONE with binary encoding.
REQ-016 IDLE: in_ready=1, round=0, round_en=0, out_valid=0.
REQ-017 In IDLE, when in_valid=1, load_en=1 in that cycle and the next state is RUN.
REQ-018 In RUN: round_en=1, in_ready=0, load_en=0, busy=1.
REQ-019 In RUN, round increments by UNROLL every cycle.
REQ-020 In RUN, when round==NUM_ROUNDS-UNROLL, the next state is DONE and round returns to 0.
REQ-021 With the input accepted in cycle T, RUN occupies cycles T+1 through T+NUM_ROUNDS/UNROLL, and out_valid first rises in cycle T+1+NUM_ROUNDS/UNROLL.
REQ-022 DONE: out_valid=1, round_en=0, round=0, and in_ready equals out_ready.
REQ-023 In DONE with out_ready=1 and in_valid=0, the next state is IDLE.
REQ-024 In DONE with out_ready=1 and in_valid=1, load_en=1 and the next state is RUN, giving back-to-back operation with no idle bubble.
REQ-025 In DONE with out_ready=0, out_valid and the state register SHALL remain stable indefinitely, and in_valid is ignored.
REQ-026 load_en and round_en SHALL never be high in the same cycle.
REQ-027 The output handshake is out_valid and out_ready both high.
REQ-028 perm_count increments by 1 on each output handshake and wraps from 16'hFFFF to 0.
REQ-029 abort=1 in any state forces the next state to IDLE and round to 0, and forces load_en=0 and round_en=0 in that cycle.
REQ-030 abort=1 clears any pending out_valid without counting, and perm_count holds.
REQ-031 abort has priority over in_valid and out_ready in the same cycle.
REQ-032 abort in IDLE has no effect except that in_valid is ignored that cycle.
REQ-033 round SHALL never exceed NUM_ROUNDS-1.
REQ-034 Any illegal state encoding returns to IDLE on the next edge.
REQ-035 All outputs SHALL be decoded from registered state and counter values, except in_ready and load_en, which may depend combinationally on in_valid and out_ready.

Reset
REQ-036 When rst_n=0 at a clock edge, the state becomes IDLE, round=0 and perm_count=0.
REQ-037 While rst_n=0: out_valid=0, busy=0, load_en=0, round_en=0 and in_ready=0.
REQ-038 Reset asserted mid-RUN discards the permutation and produces no out_valid.
REQ-039 The first cycle after rst_n rises is in IDLE with in_ready=1.

Verification
REQ-040 Basic run, UNROLL=1: in_valid pulse in cycle 0 -> load_en=1 in cycle 0; round=0..23 with round_en=1 in cycles 1..24; out_valid=1 from cycle 25; busy=1 for exactly 24 cycles.
REQ-041 Unrolled run, UNROLL=2: accept in cycle 0 -> round sequence 0,2,...,22 over 12 cycles; out_valid in cycle 13.
REQ-042 Backpressure then back-to-back: out_ready=0 for 10 cycles in DONE -> out_valid held and no round_en. Then out_ready=1 with in_valid=1 -> load_en=1 in the same cycle, next state RUN, round=0, perm_count=1.
REQ-043 Abort mid-run: abort=1 while round=10 -> IDLE next cycle, round=0, no out_valid, perm_count unchanged.
REQ-044 Reset mid-run: rst_n=0 while round=5 -> all outputs 0 and perm_count=0; IDLE with in_ready=1 the cycle after release.
REQ-045 Counter wrap: preload 65535 completions, then one more handshake -> perm_count=0.

Source files
------------

// File: rtl/keccak_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : keccak_round_ctrl_if
// Description : Handshake and datapath-control bundle between a Keccak round
//               controller and its environment.
//               master : the environment (producer/consumer) side
//               slave  : the controller side
// Signals     : in_valid/in_ready   - input handshake for a new 1600-bit state
//               out_valid/out_ready - output handshake for a finished state
//               abort               - cancel the permutation in progress
//               load_en/round_en    - state-register capture selects
//               round               - first round index applied this cycle
//               busy                - rounds are being applied
//               perm_count          - completed output handshakes (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
interface keccak_round_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        abort;
  logic        load_en;
  logic        round_en;
  logic [6:0]  round;
  logic        busy;
  logic [15:0] perm_count;

  modport master (
    output in_valid, out_ready, abort,
    input  in_ready, out_valid, load_en, round_en, round, busy, perm_count
  );

  modport slave (
    input  in_valid, out_ready, abort,
    output in_ready, out_valid, load_en, round_en, round, busy, perm_count
  );
endinterface
`default_nettype wire

// File: rtl/keccak_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : keccak_round_ctrl
// Description : Sequencer for an iterative Keccak-f permutation datapath.
//               Accepts a state (load_en), steps the round index UNROLL rounds
//               per cycle (round_en), then holds the result until the consumer
//               takes it. A new state may be accepted in the same cycle the
//               result is taken, so back-to-back permutations have no bubble.
// Parameters  : NUM_ROUNDS - rounds per permutation (must be a multiple of
//                            UNROLL)
//               UNROLL     - rounds applied per cycle (1..4)
// Ports       : clk        - clock, rising edge
//               rst_n      - synchronous active-low reset
//               bus_if     - slave side of keccak_round_ctrl_if
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_round_ctrl #(
  parameter int NUM_ROUNDS = 24,
  parameter int UNROLL     = 1
) (
  input wire                 clk,
  input wire                 rst_n,
  keccak_round_ctrl_if.slave bus_if
);

  localparam logic [6:0] c_step       = 7'(UNROLL);
  localparam logic [6:0] c_last_round = 7'(NUM_ROUNDS - UNROLL);

  // 2'b11 is unused; it falls into the default branch and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t      r_state;
  logic [6:0]  r_round;
  logic        r_busy;
  logic        r_round_en;
  logic        r_out_valid;
  logic [15:0] r_perm_count;

  logic w_in_ready;
  logic w_load;
  logic w_handshake;

  // Input is accepted from IDLE, or from DONE when the result leaves in the
  // same cycle. Abort and reset both block acceptance.
  assign w_in_ready  = rst_n & ~bus_if.abort &
                       ((r_state == ST_IDLE) |
                        ((r_state == ST_DONE) & bus_if.out_ready));
  assign w_load      = w_in_ready & bus_if.in_valid;
  // An abort in DONE discards the result, so it must not count as delivered.
  assign w_handshake = r_out_valid & bus_if.out_ready & ~bus_if.abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_round      <= 7'd0;
      r_busy       <= 1'b0;
      r_round_en   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_perm_count <= 16'd0;
    end else begin
      if (w_handshake) begin
        r_perm_count <= r_perm_count + 16'd1;
      end

      if (bus_if.abort) begin
        r_state     <= ST_IDLE;
        r_round     <= 7'd0;
        r_busy      <= 1'b0;
        r_round_en  <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_load) begin
              r_state    <= ST_RUN;
              r_round    <= 7'd0;
              r_busy     <= 1'b1;
              r_round_en <= 1'b1;
            end
          end

          ST_RUN: begin
            // '>=' keeps round bounded even if NUM_ROUNDS is not an exact
            // multiple of UNROLL.
            if (r_round >= c_last_round) begin
              r_state     <= ST_DONE;
              r_round     <= 7'd0;
              r_busy      <= 1'b0;
              r_round_en  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_round <= r_round + c_step;
            end
          end

          ST_DONE: begin
            // Without out_ready everything holds, in_valid included.
            if (bus_if.out_ready) begin
              r_out_valid <= 1'b0;
              if (w_load) begin
                r_state    <= ST_RUN;
                r_round    <= 7'd0;
                r_busy     <= 1'b1;
                r_round_en <= 1'b1;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end

          default: begin
            r_state     <= ST_IDLE;
            r_round     <= 7'd0;
            r_busy      <= 1'b0;
            r_round_en  <= 1'b0;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus_if.in_ready   = w_in_ready;
  assign bus_if.load_en    = w_load;
  assign bus_if.round_en   = r_round_en;
  assign bus_if.round      = r_round;
  assign bus_if.busy       = r_busy;
  assign bus_if.out_valid  = r_out_valid;
  assign bus_if.perm_count = r_perm_count;

endmodule
`default_nettype wire

// File: tb/tb_keccak_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_keccak_round_ctrl
// Description : Self-checking bench for keccak_round_ctrl. Two controllers
//               (UNROLL=1 and UNROLL=2) receive identical stimulus. A
//               timestamp-based model predicts every cycle's outputs and each
//               permutation's completion cycle; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_round_ctrl;

  localparam int NR   = 24;
  localparam int NDUT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keccak_round_ctrl_if if0 ();
  keccak_round_ctrl_if if1 ();

  keccak_round_ctrl #(.NUM_ROUNDS(NR), .UNROLL(1)) u_dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (if0.slave)
  );

  keccak_round_ctrl #(.NUM_ROUNDS(NR), .UNROLL(2)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (if1.slave)
  );

  // Packed view: {in_ready, load_en, round_en, out_valid, busy, round, perm_count}
  logic [27:0] act [NDUT];
  assign act[0] = {if0.in_ready, if0.load_en, if0.round_en, if0.out_valid,
                   if0.busy, if0.round, if0.perm_count};
  assign act[1] = {if1.in_ready, if1.load_en, if1.round_en, if1.out_valid,
                   if1.busy, if1.round, if1.perm_count};

  function automatic int unr(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  // Reference model: a job is described only by the cycle it was accepted in.
  bit          have_job [NDUT];
  int          acc_cyc  [NDUT];
  logic [15:0] mcount   [NDUT];
  logic [27:0] exp_q    [NDUT][$];
  int          comp_q   [NDUT][$];

  int total = 0;
  int bad   = 0;

  // Drive one cycle of inputs, predict that cycle's outputs, advance the model
  // across the following edge, then move to just after that edge.
  task automatic step(input bit iv, input bit ordy, input bit ab, input bit rn);
    rst_n         = rn;
    if0.in_valid  = iv;
    if0.out_ready = ordy;
    if0.abort     = ab;
    if1.in_valid  = iv;
    if1.out_ready = ordy;
    if1.abort     = ab;
    for (int k = 0; k < NDUT; k++) begin
      int         nr_k;
      bit         busy_e;
      bit         ov_e;
      bit         ir_e;
      bit         ld_e;
      logic [6:0] rnd_e;
      nr_k   = NR / unr(k);
      busy_e = have_job[k] && (cyc <= acc_cyc[k] + nr_k);
      ov_e   = have_job[k] && !busy_e;
      rnd_e  = busy_e ? 7'((cyc - acc_cyc[k] - 1) * unr(k)) : 7'd0;
      ir_e   = rn && !ab && (!have_job[k] || (ov_e && ordy));
      ld_e   = ir_e && iv;
      exp_q[k].push_back({ir_e, ld_e, busy_e, ov_e, busy_e, rnd_e, mcount[k]});
      if (!rn) begin
        if (busy_e) void'(comp_q[k].pop_back());
        have_job[k] = 1'b0;
        mcount[k]   = 16'd0;
      end else if (ab) begin
        if (busy_e) void'(comp_q[k].pop_back());
        have_job[k] = 1'b0;
      end else begin
        if (ov_e && ordy) begin
          mcount[k]   = mcount[k] + 16'd1;
          have_job[k] = 1'b0;
        end
        if (ld_e) begin
          have_job[k] = 1'b1;
          acc_cyc[k]  = cyc;
          comp_q[k].push_back(cyc + 1 + nr_k);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares outputs at every falling edge an expectation exists,
  // and checks the cycle in which each result first becomes valid.
  bit prev_ov [NDUT];
  initial begin
    prev_ov[0] = 1'b0;
    prev_ov[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int m = 0; m < NDUT; m++) begin
        if (exp_q[m].size() > 0) begin
          logic [27:0] e;
          e = exp_q[m].pop_front();
          total++;
          if (act[m] !== e) begin
            bad++;
            $display("FAIL outputs dut%0d cyc=%0d got=%h expected=%h",
                     m, cyc, act[m], e);
          end
        end
        if (act[m][24] && !prev_ov[m]) begin
          total++;
          if (comp_q[m].size() == 0) begin
            bad++;
            $display("FAIL completion dut%0d cyc=%0d got=unexpected_out_valid expected=none", m, cyc);
          end else begin
            int ec;
            ec = comp_q[m].pop_front();
            if (ec != cyc) begin
              bad++;
              $display("FAIL completion dut%0d got_cycle=%0d expected_cycle=%0d", m, cyc, ec);
            end
          end
        end
        prev_ov[m] = act[m][24];
      end
    end
  end

  initial begin
    bit r_iv, r_or, r_ab, r_rn;
    for (int k = 0; k < NDUT; k++) begin
      have_job[k] = 1'b0;
      acc_cyc[k]  = 0;
      mcount[k]   = 16'd0;
    end
    if0.in_valid = 1'b0; if0.out_ready = 1'b0; if0.abort = 1'b0;
    if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held, then release into IDLE.
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // Basic run, then 10+ cycles of backpressure in DONE.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (NR + 10) step(1'b1, 1'b0, 1'b0, 1'b1);
    // Back-to-back: result taken and new state accepted together.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    // Abort while the UNROLL=1 controller sits at round 10.
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    // Abort in IDLE with in_valid must not start a job.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    // Reset while the UNROLL=1 controller sits at round 5.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic, first with light backpressure, then heavy.
    for (int i = 0; i < 2000; i++) begin
      r_iv = ($urandom_range(0, 99) < 50);
      r_or = (i < 1200) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 8);
      r_ab = ($urandom_range(0, 99) < 2);
      r_rn = ($urandom_range(0, 299) != 0);
      step(r_iv, r_or, r_ab, r_rn);
    end

    // Counter wrap: preload 65535 completions, then one more handshake.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    force u_dut0.r_perm_count = 16'hFFFF;
    force u_dut1.r_perm_count = 16'hFFFF;
    mcount[0] = 16'hFFFF;
    mcount[1] = 16'hFFFF;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    release u_dut0.r_perm_count;
    release u_dut1.r_perm_count;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (NR + 2) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Drain: take every pending result.
    repeat (NR + 6) step(1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    #1;

    for (int k = 0; k < NDUT; k++) begin
      total++;
      if (comp_q[k].size() != 0) begin
        bad++;
        $display("FAIL drain dut%0d pending=%0d expected=0", k, comp_q[k].size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
